// File: rtl/pipe_wb_reg_if.sv
// MEM->WB pipeline register bus: mem-stage inputs, control, and WB-stage outputs.
// The master drives the mem-stage side. The slave is the pipeline register itself.
interface pipe_wb_reg_if #(
    parameter int NCH     = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 6,
    parameter int CNT_W   = 32
);
    logic [STALL_W-1:0]    stall;
    logic                  flush;
    logic                  in_valid;
    logic [31:0]           in_pc;
    logic [NCH-1:0]        in_we;
    logic [NCH*ADDR_W-1:0] in_waddr;
    logic [NCH*DATA_W-1:0] in_wdata;
    logic                  cnt_clr;
    logic                  out_valid;
    logic [31:0]           out_pc;
    logic [NCH-1:0]        out_we;
    logic [NCH*ADDR_W-1:0] out_waddr;
    logic [NCH*DATA_W-1:0] out_wdata;
    logic [CNT_W-1:0]      retire_cnt;

    modport master (
        output stall, flush, in_valid, in_pc, in_we, in_waddr, in_wdata, cnt_clr,
        input  out_valid, out_pc, out_we, out_waddr, out_wdata, retire_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_pc, in_we, in_waddr, in_wdata, cnt_clr,
        output out_valid, out_pc, out_we, out_waddr, out_wdata, retire_cnt
    );
endinterface

// File: rtl/pipe_wb_reg.sv
// MEM->WB pipeline register carrying NCH independent register-write channels.
// It applies the pass/hold/bubble stall rules, inserts a bubble on an exception flush,
// and gates write enables on the valid bit and the per-channel register-zero mask.
// It also keeps a saturating count of retired instructions. All outputs are registered.
module pipe_wb_reg #(
    parameter int             NCH       = 2,
    parameter int             ADDR_W    = 5,
    parameter int             DATA_W    = 32,
    parameter int             STALL_W   = 6,
    parameter int             STAGE     = 4,
    parameter logic [NCH-1:0] ZERO_MASK = NCH'(1'b1),
    parameter int             CNT_W     = 32
) (
    input logic         clk,
    input logic         rst,
    pipe_wb_reg_if.slave bus
);
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } act_e;

    logic                  ds_s;
    act_e                  act_s;
    logic [NCH-1:0]        we_gated_s;
    logic                  unused_stall_s;

    logic                  out_valid_r;
    logic [31:0]           out_pc_r;
    logic [NCH-1:0]        out_we_r;
    logic [NCH*ADDR_W-1:0] out_waddr_r;
    logic [NCH*DATA_W-1:0] out_wdata_r;
    logic [CNT_W-1:0]      retire_cnt_r;

    // Only this stage's bit and the downstream bit are consumed.
    assign unused_stall_s = ^bus.stall;

    // Downstream stop bit. The last stage in the stall vector has no downstream stage.
    generate
        if (STAGE + 1 < STALL_W) begin : g_ds
            assign ds_s = bus.stall[STAGE+1];
        end else begin : g_no_ds
            assign ds_s = 1'b0;
        end
    endgenerate

    // Choose this cycle's action, in priority order: flush, bubble, load, hold.
    always_comb begin
        act_s = ACT_HOLD;
        if (bus.flush) begin
            act_s = ACT_BUBBLE;
        end else if (bus.stall[STAGE] && !ds_s) begin
            act_s = ACT_BUBBLE;
        end else if (!bus.stall[STAGE]) begin
            act_s = ACT_LOAD;
        end else begin
            act_s = ACT_HOLD;
        end
    end

    // Write enables: only valid instructions write, and masked channels never write register 0.
    always_comb begin
        we_gated_s = '0;
        for (int c = 0; c < NCH; c++) begin
            we_gated_s[c] = bus.in_we[c] & bus.in_valid &
                            ~(ZERO_MASK[c] & (bus.in_waddr[c*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}}));
        end
    end

    // Pipeline register: clear on reset, otherwise load, bubble or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_pc_r    <= 32'h0;
            out_we_r    <= '0;
            out_waddr_r <= '0;
            out_wdata_r <= '0;
        end else begin
            case (act_s)
                ACT_LOAD: begin
                    out_valid_r <= bus.in_valid;
                    out_pc_r    <= bus.in_pc;
                    out_we_r    <= we_gated_s;
                    out_waddr_r <= bus.in_waddr;
                    out_wdata_r <= bus.in_wdata;
                end
                ACT_BUBBLE: begin
                    out_valid_r <= 1'b0;
                    out_pc_r    <= 32'h0;
                    out_we_r    <= '0;
                    out_waddr_r <= '0;
                    out_wdata_r <= '0;
                end
                ACT_HOLD: begin
                    out_valid_r <= out_valid_r;
                    out_pc_r    <= out_pc_r;
                    out_we_r    <= out_we_r;
                    out_waddr_r <= out_waddr_r;
                    out_wdata_r <= out_wdata_r;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    out_pc_r    <= 32'h0;
                    out_we_r    <= '0;
                    out_waddr_r <= '0;
                    out_wdata_r <= '0;
                end
            endcase
        end
    end

    // Retire counter: clear wins over increment. It counts valid loads and saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_r <= '0;
        end else if (bus.cnt_clr) begin
            retire_cnt_r <= '0;
        end else if ((act_s == ACT_LOAD) && bus.in_valid && (retire_cnt_r != {CNT_W{1'b1}})) begin
            retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.out_pc     = out_pc_r;
    assign bus.out_we     = out_we_r;
    assign bus.out_waddr  = out_waddr_r;
    assign bus.out_wdata  = out_wdata_r;
    assign bus.retire_cnt = retire_cnt_r;
endmodule
